// File: rtl/grid_scan_reader.sv
// -----------------------------------------------------------------------------
// grid_scan_reader
//
// Read-side scanner for the player grid register bank. A start pulse takes a
// snapshot of the eight wall/location coordinate vectors. The block then
// streams every cell (x,y) in row-major order, x fastest, as a classified
// 3-bit cell code over a valid/ready handshake. Crash flags for each player
// are accumulated over the scan. A one-cycle done pulse follows the last
// transfer.
//
// Configuration macro:
//   SKIP_EMPTY_EN  When defined, empty (code 0) cells are never presented.
//                  The scanner steps over them internally at one cell per
//                  cycle with out_valid low.
//
// Parameters:
//   gridWidth   number of columns (width of every *_x vector)
//   gridHeight  number of rows    (width of every *_y vector)
//
// Ports:
//   clock               single clock; all state changes on posedge
//   reset               synchronous, active-high
//   start               one-cycle scan request; ignored unless idle
//   wall_p1_x/_y        P1 wall column/row vectors
//   wall_p2_x/_y        P2 wall column/row vectors
//   LOC_p1_x/_y         P1 head column/row vectors
//   LOC_p2_x/_y         P2 head column/row vectors
//   busy                high while scanning
//   out_valid           cell_x/cell_y/cell_code carry a cell
//   out_ready           consumer accepts the presented cell this cycle
//   cell_x, cell_y      coordinates of the current cell
//   cell_code           0 empty, 1 P1 wall, 2 P2 wall, 3 P1 head,
//                       4 P2 head, 5 head-on
//   done                one-cycle pulse after the final cell
//   crash_p1, crash_p2  per-player crash result of the last scan
// -----------------------------------------------------------------------------
module grid_scan_reader #(
  parameter  int gridWidth  = 32,
  parameter  int gridHeight = 32,
  localparam int XW         = $clog2(gridWidth),
  localparam int YW         = $clog2(gridHeight)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [gridWidth-1:0]  wall_p1_x,
  input  logic [gridWidth-1:0]  wall_p2_x,
  input  logic [gridWidth-1:0]  LOC_p1_x,
  input  logic [gridWidth-1:0]  LOC_p2_x,
  input  logic [gridHeight-1:0] wall_p1_y,
  input  logic [gridHeight-1:0] wall_p2_y,
  input  logic [gridHeight-1:0] LOC_p1_y,
  input  logic [gridHeight-1:0] LOC_p2_y,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XW-1:0]         cell_x,
  output logic [YW-1:0]         cell_y,
  output logic [2:0]            cell_code,
  output logic                  done,
  output logic                  crash_p1,
  output logic                  crash_p2
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    CODE_EMPTY   = 3'd0,
    CODE_P1_WALL = 3'd1,
    CODE_P2_WALL = 3'd2,
    CODE_P1_HEAD = 3'd3,
    CODE_P2_HEAD = 3'd4,
    CODE_HEAD_ON = 3'd5
  } cell_code_e;

  // Frozen copy of the coordinate vectors, taken when a scan is accepted.
  typedef struct packed {
    logic [gridWidth-1:0]  w1x;
    logic [gridWidth-1:0]  w2x;
    logic [gridWidth-1:0]  h1x;
    logic [gridWidth-1:0]  h2x;
    logic [gridHeight-1:0] w1y;
    logic [gridHeight-1:0] w2y;
    logic [gridHeight-1:0] h1y;
    logic [gridHeight-1:0] h2y;
  } snap_t;

  localparam logic [XW-1:0] LastX = XW'(gridWidth - 1);
  localparam logic [YW-1:0] LastY = YW'(gridHeight - 1);

  state_e        state_q, state_d;
  snap_t         snap_q, snap_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          crash_p1_q, crash_p1_d;
  logic          crash_p2_q, crash_p2_d;

  // Classification of the current cell, always from the snapshot.
  logic       w1, w2, h1, h2;
  cell_code_e code;
  logic       crash1_hit, crash2_hit;

  always_comb begin
    w1 = snap_q.w1x[x_q] & snap_q.w1y[y_q];
    w2 = snap_q.w2x[x_q] & snap_q.w2y[y_q];
    h1 = snap_q.h1x[x_q] & snap_q.h1y[y_q];
    h2 = snap_q.h2x[x_q] & snap_q.h2y[y_q];

    if (h1 && h2)  code = CODE_HEAD_ON;
    else if (h1)   code = CODE_P1_HEAD;
    else if (h2)   code = CODE_P2_HEAD;
    else if (w1)   code = CODE_P1_WALL;
    else if (w2)   code = CODE_P2_WALL;
    else           code = CODE_EMPTY;

    crash1_hit = h1 & (w1 | w2 | h2);
    crash2_hit = h2 & (w1 | w2 | h1);
  end

  // Next-state and output logic.
  logic present;  // current cell is offered to the consumer
  logic xfer;     // handshake completes this cycle
  logic advance;  // step to the next cell this cycle

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned
    // and no latch is inferred.
    state_d    = state_q;
    snap_d     = snap_q;
    x_d        = x_q;
    y_d        = y_q;
    crash_p1_d = crash_p1_q;
    crash_p2_d = crash_p2_q;
    present    = 1'b0;
    xfer       = 1'b0;
    advance    = 1'b0;
    busy       = 1'b0;
    out_valid  = 1'b0;
    done       = 1'b0;
    cell_code  = CODE_EMPTY;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_SCAN;
          snap_d     = '{w1x: wall_p1_x, w2x: wall_p2_x,
                         h1x: LOC_p1_x,  h2x: LOC_p2_x,
                         w1y: wall_p1_y, w2y: wall_p2_y,
                         h1y: LOC_p1_y,  h2y: LOC_p2_y};
          x_d        = '0;
          y_d        = '0;
          crash_p1_d = 1'b0;
          crash_p2_d = 1'b0;
        end
      end

      ST_SCAN: begin
        busy = 1'b1;
`ifdef SKIP_EMPTY_EN
        present = (code != CODE_EMPTY);
`else
        present = 1'b1;
`endif
        out_valid = present;
        cell_code = code;
        xfer      = present & out_ready;
        // Hidden empty cells need no consumer acceptance to be stepped over.
        advance   = xfer | ~present;

        if (xfer) begin
          crash_p1_d = crash_p1_q | crash1_hit;
          crash_p2_d = crash_p2_q | crash2_hit;
        end

        // Explicit end-of-row/end-of-grid compares keep non-power-of-2
        // sizes correct without relying on counter overflow.
        if (advance) begin
          if (x_q == LastX) begin
            x_d = '0;
            if (y_q == LastY) begin
              y_d     = '0;
              state_d = ST_DONE;
            end else begin
              y_d = y_q + YW'(1);
            end
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q    <= ST_IDLE;
      // NOTE: the snapshot is cleared on reset so cell_code is defined from reset.
      snap_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      crash_p1_q <= 1'b0;
      crash_p2_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      snap_q     <= snap_d;
      x_q        <= x_d;
      y_q        <= y_d;
      crash_p1_q <= crash_p1_d;
      crash_p2_q <= crash_p2_d;
    end
  end

  assign cell_x   = x_q;
  assign cell_y   = y_q;
  assign crash_p1 = crash_p1_q;
  assign crash_p2 = crash_p2_q;

endmodule

// File: tb/tb_grid_scan_reader.sv
// -----------------------------------------------------------------------------
// tb_grid_scan_reader
//
// Directed bench for grid_scan_reader at its default 32x32 size. A negedge
// monitor records every handshake transfer and every done pulse. It also
// tracks output stability during stalls. Each scan is compared against the
// cell classification of the vectors that were present at start. Specific
// cells, crash flags and the done latency are checked against hand-derived
// constants.
// -----------------------------------------------------------------------------
module tb_grid_scan_reader;

  localparam int W = 32;
  localparam int H = 32;
`ifdef SKIP_EMPTY_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset, start, out_ready;
  logic [W-1:0] wall_p1_x, wall_p2_x, LOC_p1_x, LOC_p2_x;
  logic [H-1:0] wall_p1_y, wall_p2_y, LOC_p1_y, LOC_p2_y;
  logic         busy, out_valid, done, crash_p1, crash_p2;
  logic [4:0]   cell_x, cell_y;
  logic [2:0]   cell_code;

  grid_scan_reader #(.gridWidth(W), .gridHeight(H)) dut (
    .clock(clock), .reset(reset), .start(start),
    .wall_p1_x(wall_p1_x), .wall_p2_x(wall_p2_x),
    .LOC_p1_x(LOC_p1_x), .LOC_p2_x(LOC_p2_x),
    .wall_p1_y(wall_p1_y), .wall_p2_y(wall_p2_y),
    .LOC_p1_y(LOC_p1_y), .LOC_p2_y(LOC_p2_y),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .cell_x(cell_x), .cell_y(cell_y), .cell_code(cell_code),
    .done(done), .crash_p1(crash_p1), .crash_p2(crash_p2)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  typedef struct {
    int x;
    int y;
    int code;
  } xfer_t;

  xfer_t       q[$];
  int          cyc = 0;
  int          done_n = 0;
  int          done_cyc = 0;
  int          start_cyc = 0;
  int          stall_bad = 0;
  logic        prev_stall = 1'b0;
  logic [13:0] prev_out = '0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && ({out_valid, cell_x, cell_y, cell_code} !== prev_out))
        stall_bad++;
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_valid, cell_x, cell_y, cell_code};
      if (out_valid && out_ready)
        q.push_back('{x: int'(cell_x), y: int'(cell_y), code: int'(cell_code)});
      if (done) begin
        done_n++;
        done_cyc = cyc;
      end
    end
  end

  // ------------------------------------------------------- reference model
  logic [W-1:0] e_w1x, e_w2x, e_h1x, e_h2x;
  logic [H-1:0] e_w1y, e_w2y, e_h1y, e_h2y;

  function automatic int model(input int x, input int y);
    logic w1, w2, h1, h2;
    w1 = e_w1x[x] & e_w1y[y];
    w2 = e_w2x[x] & e_w2y[y];
    h1 = e_h1x[x] & e_h1y[y];
    h2 = e_h2x[x] & e_h2y[y];
    if (h1 && h2) return 5;
    if (h1)       return 3;
    if (h2)       return 4;
    if (w1)       return 1;
    if (w2)       return 2;
    return 0;
  endfunction

  function automatic int find(input int x, input int y);
    foreach (q[i]) if (q[i].x == x && q[i].y == y) return q[i].code;
    return 7;
  endfunction

  task automatic set_vec(input logic [W-1:0] w1x, w1y, w2x, w2y, h1x, h1y, h2x, h2y);
    wall_p1_x = w1x; wall_p1_y = w1y; wall_p2_x = w2x; wall_p2_y = w2y;
    LOC_p1_x  = h1x; LOC_p1_y  = h1y; LOC_p2_x  = h2x; LOC_p2_y  = h2y;
  endtask

  task automatic issue_start();
    q.delete();
    done_n = 0;
    e_w1x = wall_p1_x; e_w1y = wall_p1_y; e_w2x = wall_p2_x; e_w2y = wall_p2_y;
    e_h1x = LOC_p1_x;  e_h1y = LOC_p1_y;  e_h2x = LOC_p2_x;  e_h2y = LOC_p2_y;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic run_scan(input string tag, input bit rnd, input bit disturb);
    issue_start();
    for (int i = 0; i < 8000 && done_n == 0; i++) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      if (disturb && i == 50) begin
        set_vec('1, '1, '1, '1, '1, '1, '1, '1);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clock); #1;
    end
    out_ready = 1'b1;
    start     = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check({tag, "_done_pulses"}, done_n, 1);
  endtask

  task automatic check_stream(input string tag);
    int n = 0;
    int mism = 0;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        int c;
        c = model(x, y);
        if (!(SKIP && c == 0)) begin
          if (n < q.size()) begin
            if (q[n].x != x || q[n].y != y || q[n].code != c) mism++;
          end
          n++;
        end
      end
    end
    check({tag, "_len"}, q.size(), n);
    check({tag, "_data"}, mism, 0);
  endtask

  // -------------------------------------------------------------- stimulus
  initial begin
    reset = 1'b1; start = 1'b0; out_ready = 1'b1;
    set_vec('0, '0, '0, '0, '0, '0, '0, '0);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    // 1: idle after reset
    repeat (5) @(posedge clock);
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_done", done, 0);
    check("rst_crash_p1", crash_p1, 0);
    check("rst_crash_p2", crash_p2, 0);
    check("rst_cell_x", cell_x, 0);
    check("rst_code", cell_code, 0);

    // 2: single P1 wall cell at (3,2)
    set_vec(32'h8, 32'h4, '0, '0, '0, '0, '0, '0);
    run_scan("t2", 1'b0, 1'b0);
    check_stream("t2");
    check("t2_cell_3_2", find(3, 2), 1);
    check("t2_done_latency", done_cyc - start_cyc, 1025);
    check("t2_len_hand", q.size(), SKIP ? 1 : 1024);
    check("t2_crash_p1", crash_p1, 0);
    check("t2_crash_p2", crash_p2, 0);

    // 3: P1 head on a P2 wall at (5,5)
    set_vec('0, '0, 32'h20, 32'h20, 32'h20, 32'h20, '0, '0);
    run_scan("t3", 1'b0, 1'b0);
    check_stream("t3");
    check("t3_cell_5_5", find(5, 5), 3);
    check("t3_crash_p1", crash_p1, 1);
    check("t3_crash_p2", crash_p2, 0);

    // 4: head-on at (0,0)
    set_vec('0, '0, '0, '0, 32'h1, 32'h1, 32'h1, 32'h1);
    run_scan("t4", 1'b0, 1'b0);
    check_stream("t4");
    check("t4_first_x", q.size() > 0 ? q[0].x : -1, 0);
    check("t4_first_code", q.size() > 0 ? q[0].code : -1, 5);
    check("t4_crash_p1", crash_p1, 1);
    check("t4_crash_p2", crash_p2, 1);

    // 5: random stalls, live inputs changed and start pulsed mid-scan.
    //    P1 walls at x 4..7, y 8..9; P1 head at (4,9) on a wall; P2 head at (7,20).
    set_vec(32'h0000_00F0, 32'h0000_0300, '0, '0,
            32'h0000_0010, 32'h0000_0200, 32'h0000_0080, 32'h0010_0000);
    run_scan("t5", 1'b1, 1'b1);
    check_stream("t5");
    check("t5_cell_4_9", find(4, 9), 3);
    check("t5_cell_7_20", find(7, 20), 4);
    check("t5_cell_6_8", find(6, 8), 1);
    check("t5_crash_p1", crash_p1, 1);
    check("t5_crash_p2", crash_p2, 0);
    check("t5_stall_stable", stall_bad, 0);

    // 6: reset while the scanner sits at cell (10,4), then a fresh scan
    set_vec(32'h8, 32'h4, '0, '0, '0, '0, '0, '0);
    issue_start();
    begin
      bit hit = 1'b0;
      for (int i = 0; i < 2000 && !hit; i++) begin
        if (cell_x == 5'd10 && cell_y == 5'd4) hit = 1'b1;
        else begin
          @(posedge clock); #1;
        end
      end
      check("t6_reached_10_4", hit, 1);
    end
    reset = 1'b1;
    @(posedge clock); #1;
    check("t6_busy", busy, 0);
    check("t6_valid", out_valid, 0);
    check("t6_cell_x", cell_x, 0);
    reset = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    check("t6_no_done", done_n, 0);
    check("t6_idle_valid", out_valid, 0);
    run_scan("t6b", 1'b0, 1'b0);
    check_stream("t6b");
    check("t6b_len_hand", q.size(), SKIP ? 1 : 1024);
    check("t6b_cell_3_2", find(3, 2), 1);

    check("stall_stable_all", stall_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
